instruction_fetch_unit: RTL and testbench

Front-end stage directly upstream of control_unit. Holds the program counter, issues 20-bit instruction-word reads to instruction memory over a req/ack handshake, and presents the fetched word on instruction/instr_valid to control_unit when control_unit asserts fetch_enable. Accepts branch/jump redirects from the execute stage, squashes in-flight fetches, and raises trap and memory-violation conditions.

---
 rtl/instruction_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction words over a req/ack handshake
// and hands them to control_unit, with branch redirect, squash, trap and fault.
module instruction_fetch_unit #(
  parameter int unsigned       WORD_W    = 20,
  parameter int unsigned       ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_enable,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_violation_flag,
  output logic              trap_mode_flag
);

  // One extra bit so MEM_WORDS == 2**ADDR_W is still representable.
  localparam int unsigned        LIM_W     = ADDR_W + 1;
  localparam logic [LIM_W-1:0]   MEM_LIMIT = LIM_W'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, TRAP, FAULT} state_t;

  state_t state;
  logic   squash;
  logic   pc_oob_c;

  assign pc_oob_c = ({1'b0, pc} >= MEM_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      pc                 <= RESET_PC;
      imem_req           <= 1'b0;
      imem_addr          <= '0;
      instruction        <= '0;
      instr_valid        <= 1'b0;
      mem_violation_flag <= 1'b0;
      trap_mode_flag     <= 1'b0;
      squash             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_taken) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else if (fetch_enable && !stall) begin
            if (pc_oob_c) begin
              mem_violation_flag <= 1'b1;
              state              <= FAULT;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
              state     <= REQ;
            end
          end
        end

        // Request stays up until ack; a redirect without ack only marks it stale.
        REQ: begin
          if (branch_taken) begin
            pc <= branch_target;
            if (imem_ack) begin
              imem_req <= 1'b0;
              squash   <= 1'b0;
              state    <= IDLE;
            end else begin
              squash <= 1'b1;
            end
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            if (squash) begin
              squash <= 1'b0;
              state  <= IDLE;
            end else begin
              instruction <= imem_rdata;
              instr_valid <= 1'b1;
              pc          <= pc + ADDR_W'(1);
              if (imem_rdata == '0) begin
                trap_mode_flag <= 1'b1;
                state          <= TRAP;
              end else begin
                state <= HOLD;
              end
            end
          end
        end

        HOLD: begin
          if (branch_taken) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
            state       <= IDLE;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end

        // Trap word is still handed over; only a redirect leaves this state.
        TRAP: begin
          if (branch_taken) begin
            pc             <= branch_target;
            trap_mode_flag <= 1'b0;
            instr_valid    <= 1'b0;
            state          <= IDLE;
          end else if (!stall) begin
            instr_valid <= 1'b0;
          end
        end

        FAULT: begin
          imem_req           <= 1'b0;
          instr_valid        <= 1'b0;
          mem_violation_flag <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: event-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_instruction_fetch_unit;

  localparam int unsigned WORD_W    = 20;
  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned MEM_WORDS = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_enable = 1'b0;
  logic              stall = 1'b0;
  logic              branch_taken = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              imem_ack = 1'b0;
  logic [WORD_W-1:0] imem_rdata = '0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              mem_violation_flag;
  logic              trap_mode_flag;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  localparam logic [WORD_W-1:0] W0 = 20'b00100110010100000010;

  instruction_fetch_unit #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RESET_PC('0), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .mem_violation_flag(mem_violation_flag), .trap_mode_flag(trap_mode_flag)
  );

  always #5 clk = ~clk;

  // Reference model in terms of transactions: an outstanding read, whether
  // its answer is stale, the word waiting for the consumer, and sticky modes.
  logic [ADDR_W-1:0] m_pc, m_out_addr;
  logic [WORD_W-1:0] m_word;
  bit m_outstanding, m_drop, m_word_valid, m_trapped, m_faulted;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= '0; m_out_addr <= '0; m_word <= '0;
      m_outstanding <= 0; m_drop <= 0; m_word_valid <= 0; m_trapped <= 0; m_faulted <= 0;
    end else if (!m_faulted) begin
      if (branch_taken) begin
        m_pc         <= branch_target;
        m_word_valid <= 0;
        m_trapped    <= 0;
        if (m_outstanding) begin
          if (imem_ack) begin
            m_outstanding <= 0;
            m_drop        <= 0;
          end else begin
            m_drop <= 1;
          end
        end
      end else if (m_outstanding) begin
        if (imem_ack) begin
          m_outstanding <= 0;
          if (m_drop) m_drop <= 0;
          else begin
            m_word       <= imem_rdata;
            m_word_valid <= 1;
            m_pc         <= m_pc + ADDR_W'(1);
            m_trapped    <= (imem_rdata == '0);
          end
        end
      end else if (m_word_valid) begin
        if (!stall) m_word_valid <= 0;
      end else if (!m_trapped && fetch_enable && !stall) begin
        if (int'(m_pc) >= int'(MEM_WORDS)) m_faulted <= 1;
        else begin
          m_outstanding <= 1;
          m_out_addr    <= m_pc;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_req", 32'(imem_req), 32'(m_outstanding));
      if (m_outstanding) check("model_addr", 32'(imem_addr), 32'(m_out_addr));
      check("model_valid", 32'(instr_valid), 32'(m_word_valid));
      if (m_word_valid) check("model_instr", 32'(instruction), 32'(m_word));
      check("model_pc", 32'(pc), 32'(m_pc));
      check("model_viol", 32'(mem_violation_flag), 32'(m_faulted));
      check("model_trap", 32'(trap_mode_flag), 32'(m_trapped));
    end
  end

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic cyc(input logic fe, input logic st, input logic br, input logic [ADDR_W-1:0] tgt,
                     input logic ack, input logic [WORD_W-1:0] rd);
    fetch_enable = fe; stall = st; branch_taken = br; branch_target = tgt;
    imem_ack = ack; imem_rdata = rd;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    32'(pc), 32'h0);
    check({tag, "_req"},   32'(imem_req), 32'h0);
    check({tag, "_addr"},  32'(imem_addr), 32'h0);
    check({tag, "_instr"}, 32'(instruction), 32'h0);
    check({tag, "_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_viol"},  32'(mem_violation_flag), 32'h0);
    check({tag, "_trap"},  32'(trap_mode_flag), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0; started = 1'b1;

    // Basic fetch at address 0, ack one cycle after the request appears.
    cyc(1, 0, 0, '0, 0, '0);
    check("basic_req", 32'(imem_req), 32'h1);
    check("basic_addr", 32'(imem_addr), 32'h0);
    cyc(1, 1, 0, '0, 0, '0);
    check("basic_wait_valid", 32'(instr_valid), 32'h0);
    cyc(1, 1, 0, '0, 1, W0);
    check("basic_instr", 32'(instruction), 32'(W0));
    check("basic_valid", 32'(instr_valid), 32'h1);
    check("basic_pc", 32'(pc), 32'h1);

    // Stall holds the word and blocks new requests.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, '0, 0, '0);
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_instr", 32'(instruction), 32'(W0));
      check("stall_noreq", 32'(imem_req), 32'h0);
    end
    cyc(1, 0, 0, '0, 0, '0);
    check("consume_valid", 32'(instr_valid), 32'h0);
    cyc(1, 0, 0, '0, 0, '0);
    check("next_req", 32'(imem_req), 32'h1);
    check("next_addr", 32'(imem_addr), 32'h1);
    cyc(1, 0, 0, '0, 1, 20'h12345);
    check("second_instr", 32'(instruction), 32'h12345);
    cyc(1, 0, 0, '0, 0, '0);

    // Trap on an all-zero word.
    cyc(1, 0, 0, '0, 0, '0);
    check("trap_req_addr", 32'(imem_addr), 32'h2);
    cyc(1, 0, 0, '0, 1, '0);
    check("trap_flag", 32'(trap_mode_flag), 32'h1);
    check("trap_valid", 32'(instr_valid), 32'h1);
    check("trap_pc", 32'(pc), 32'h3);
    cyc(1, 0, 0, '0, 0, '0);
    check("trap_consumed", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, '0, 0, '0);
      check("trap_noreq", 32'(imem_req), 32'h0);
      check("trap_sticky", 32'(trap_mode_flag), 32'h1);
    end
    cyc(1, 0, 1, 20'h00010, 0, '0);
    check("trap_clear", 32'(trap_mode_flag), 32'h0);
    check("trap_redirect_pc", 32'(pc), 32'h10);
    cyc(1, 0, 0, '0, 0, '0);
    check("trap_handler_addr", 32'(imem_addr), 32'h10);
    cyc(0, 0, 0, '0, 1, 20'h11111);
    check("handler_pc", 32'(pc), 32'h11);

    // Branch while holding (with stall) drops the word.
    cyc(0, 1, 1, 20'h00005, 0, '0);
    check("hold_branch_valid", 32'(instr_valid), 32'h0);
    check("hold_branch_pc", 32'(pc), 32'h5);

    // Squash: redirect while request to 5 outstanding, ack three cycles later.
    cyc(1, 0, 0, '0, 0, '0);
    check("sq_req_addr", 32'(imem_addr), 32'h5);
    cyc(0, 0, 1, 20'h00002, 0, '0);
    check("sq_pc", 32'(pc), 32'h2);
    check("sq_req_held", 32'(imem_req), 32'h1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, '0, 0, '0);
      check("sq_addr_stable", 32'(imem_addr), 32'h5);
    end
    cyc(0, 0, 0, '0, 1, 20'hABCDE);
    check("sq_dropped", 32'(instr_valid), 32'h0);
    check("sq_req_done", 32'(imem_req), 32'h0);
    cyc(1, 0, 0, '0, 0, '0);
    check("sq_next_addr", 32'(imem_addr), 32'h2);

    // Branch and ack in the same cycle.
    cyc(0, 0, 1, 20'h00030, 1, 20'h77777);
    check("simul_valid", 32'(instr_valid), 32'h0);
    check("simul_pc", 32'(pc), 32'h30);
    check("simul_req", 32'(imem_req), 32'h0);
    cyc(1, 0, 0, '0, 0, '0);
    cyc(0, 0, 0, '0, 1, 20'h5A5A5);
    check("simul_after_instr", 32'(instruction), 32'h5A5A5);
    check("simul_after_valid", 32'(instr_valid), 32'h1);
    cyc(0, 0, 0, '0, 0, '0);

    // Last legal word, then the first illegal one.
    cyc(0, 0, 1, 20'h003FF, 0, '0);
    cyc(1, 0, 0, '0, 0, '0);
    check("edge_req_addr", 32'(imem_addr), 32'h3FF);
    cyc(0, 0, 0, '0, 1, 20'h00001);
    check("edge_pc", 32'(pc), 32'h400);
    cyc(0, 0, 0, '0, 0, '0);
    check("edge_no_fault_yet", 32'(mem_violation_flag), 32'h0);
    cyc(1, 0, 0, '0, 0, '0);
    check("viol_flag", 32'(mem_violation_flag), 32'h1);
    check("viol_noreq", 32'(imem_req), 32'h0);
    cyc(1, 0, 1, 20'h00000, 0, '0);
    check("viol_branch_ignored", 32'(pc), 32'h400);
    check("viol_sticky", 32'(mem_violation_flag), 32'h1);

    // Async reset out of FAULT, then mid-request.
    reset = 1'b1;
    #1;
    check("async_clear_viol", 32'(mem_violation_flag), 32'h0);
    cyc(0, 0, 0, '0, 0, '0);
    reset = 1'b0;
    cyc(1, 0, 0, '0, 0, '0);
    check("rst_req_up", 32'(imem_req), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midreq");
    cyc(0, 0, 0, '0, 0, '0);
    reset = 1'b0;
    cyc(0, 0, 0, '0, 1, 20'h12345);
    check("stale_ack_valid", 32'(instr_valid), 32'h0);
    check("stale_ack_pc", 32'(pc), 32'h0);
    cyc(1, 0, 0, '0, 0, '0);
    check("post_reset_addr", 32'(imem_addr), 32'h0);
    check("post_reset_req", 32'(imem_req), 32'h1);
    cyc(0, 0, 0, '0, 0, '0);

    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
